race_controller: RTL

- Top-level race sequencer for the two-player racer.
- Generates the 3-bit game `state` consumed by both physics engines (3'd4 = racing).
- Consumes each engine's checkpoint `flag` and `finish` outputs and decides the race outcome.
- Provides the countdown, the race timer, the winner, and the current leader to the HUD/VGA renderer. Also issues the reset pulse that re-arms both engines before each race.

---
 rtl/race_pkg.sv | 31 +++
 rtl/game_tick_gen.sv | 25 ++
 rtl/race_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared race constants: game state codes, winner codes and timer payload.
package race_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned SEC_W          = 10;
  localparam int unsigned FRAME_W        = 6;
  localparam int unsigned FRAMES_PER_SEC = 60;

  // Game state codes; the physics engines decode the same values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd2,
    ST_RACE   = 3'd4,
    ST_FINISH = 3'd5,
    ST_RESULT = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_P1   = 2'd1,
    W_P2   = 2'd2,
    W_TIE  = 2'd3
  } winner_t;

  // Race timer as shown on the HUD.
  typedef struct packed {
    logic [SEC_W-1:0]   sec;
    logic [FRAME_W-1:0] frac;
  } race_time_t;

endpackage

// File: rtl/game_tick_gen.sv
// Free-running frame-rate tick: one-cycle pulse every CLK_FREQ/RATE cycles.
module game_tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned RATE     = 60
) (
  input  logic clk,
  input  logic rst,
  output logic game_tick
);

  localparam int unsigned PERIOD = CLK_FREQ / RATE;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt;

  assign game_tick = (cnt == CNT_W'(PERIOD - 1));

  // Counter wraps to zero on the tick cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= '0;
    else if (game_tick) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: countdown, race timer, finish arbitration, leader and engine re-arm.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC   = 3,
  parameter int unsigned FINISH_HOLD_SEC = 5,
  parameter int unsigned MAX_SEC         = 999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_btn,
  input  logic         abort_btn,
  input  logic [1:0]   p1_flag,
  input  logic [1:0]   p2_flag,
  input  logic         p1_finish,
  input  logic         p2_finish,
  output logic [2:0]   state,
  output logic         engine_rst,
  output logic [1:0]   countdown,
  output logic [9:0]   time_sec,
  output logic [5:0]   time_frac,
  output logic [1:0]   winner,
  output logic [1:0]   leader
);

  localparam int unsigned HOLD_TICKS = FINISH_HOLD_SEC * FRAMES_PER_SEC;
  localparam int unsigned CNT_MAX    = (HOLD_TICKS > FRAMES_PER_SEC) ? HOLD_TICKS : FRAMES_PER_SEC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);

  state_t           cur_state, nxt_state;
  logic [1:0]       cd_q, cd_d;
  logic [CNT_W-1:0] sub_q, sub_d;
  race_time_t       tm_q, tm_d;
  winner_t          win_q, win_d;
  logic [1:0]       lead_q, lead_d;
  logic             erst_q, erst_d;
  logic             start_q, abort_q;
  logic             start_rise, abort_rise;
  logic             game_tick;
  logic             abortable;

  game_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .RATE     (FRAMES_PER_SEC)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .game_tick (game_tick)
  );

  assign start_rise = start_btn & ~start_q;
  assign abort_rise = abort_btn & ~abort_q;
  assign abortable  = (cur_state == ST_COUNT) || (cur_state == ST_RACE) ||
                      (cur_state == ST_FINISH) || (cur_state == ST_RESULT);

  assign state      = cur_state;
  assign engine_rst = erst_q;
  assign countdown  = cd_q;
  assign time_sec   = tm_q.sec;
  assign time_frac  = tm_q.frac;
  assign winner     = win_q;
  assign leader     = lead_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= ST_IDLE;
    else      cur_state <= nxt_state;
  end

  // Datapath registers and button edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q    <= 2'd0;
      sub_q   <= '0;
      tm_q    <= '0;
      win_q   <= W_NONE;
      lead_q  <= 2'd0;
      erst_q  <= 1'b1;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cd_q    <= cd_d;
      sub_q   <= sub_d;
      tm_q    <= tm_d;
      win_q   <= win_d;
      lead_q  <= lead_d;
      erst_q  <= erst_d;
      start_q <= start_btn;
      abort_q <= abort_btn;
    end
  end

  // Next-state and datapath update; abort outranks finish and timeout.
  always_comb begin
    nxt_state = cur_state;
    cd_d      = cd_q;
    sub_d     = sub_q;
    tm_d      = tm_q;
    win_d     = win_q;
    erst_d    = 1'b0;
    lead_d    = 2'd0;

    if (cur_state == ST_RACE) begin
      if (p1_flag > p2_flag)      lead_d = 2'd1;
      else if (p1_flag < p2_flag) lead_d = 2'd2;
    end

    if (abort_rise && abortable) begin
      nxt_state = ST_IDLE;
      cd_d      = 2'd0;
      sub_d     = '0;
      tm_d      = '0;
      win_d     = W_NONE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start_rise) begin
            nxt_state = ST_COUNT;
            erst_d    = 1'b1;
            cd_d      = 2'(COUNTDOWN_SEC);
            sub_d     = '0;
            tm_d      = '0;
            win_d     = W_NONE;
          end
        end
        ST_COUNT: begin
          if (game_tick) begin
            if (sub_q == CNT_W'(FRAMES_PER_SEC - 1)) begin
              sub_d = '0;
              if (cd_q == 2'd1) begin
                cd_d      = 2'd0;
                nxt_state = ST_RACE;
              end else begin
                cd_d = cd_q - 2'd1;
              end
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
        ST_RACE: begin
          if (p1_finish || p2_finish) begin
            nxt_state = ST_FINISH;
            sub_d     = '0;
            if (p1_finish && p2_finish) win_d = W_TIE;
            else if (p1_finish)         win_d = W_P1;
            else                        win_d = W_P2;
          end else if (game_tick) begin
            if (tm_q.sec == SEC_W'(MAX_SEC) && tm_q.frac == FRAME_W'(FRAMES_PER_SEC - 1)) begin
              nxt_state = ST_FINISH;
              sub_d     = '0;
              win_d     = W_NONE;
            end else if (tm_q.frac == FRAME_W'(FRAMES_PER_SEC - 1)) begin
              tm_d.frac = '0;
              tm_d.sec  = tm_q.sec + 1'b1;
            end else begin
              tm_d.frac = tm_q.frac + 1'b1;
            end
          end
        end
        ST_FINISH: begin
          if (game_tick) begin
            if (sub_q == CNT_W'(HOLD_TICKS - 1)) nxt_state = ST_RESULT;
            else                                 sub_d     = sub_q + 1'b1;
          end
        end
        ST_RESULT: begin
          if (start_rise) nxt_state = ST_IDLE;
        end
        default: begin
          nxt_state = ST_IDLE;
          cd_d      = 2'd0;
          sub_d     = '0;
          tm_d      = '0;
          win_d     = W_NONE;
        end
      endcase
    end
  end

endmodule
